// File: rtl/multiplication_signed_32_pkg.sv
// rtl/multiplication_signed_32_pkg.sv - shared FSM state type and width constants for the signed multiplier
package multiplication_signed_32_pkg;

   localparam int OPERAND_WIDTH    = 32;
   localparam int PRODUCT_WIDTH    = 64;
   localparam int MULT_STEPS       = 32;
   localparam int STEP_COUNT_WIDTH = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mult_state_t;

endpackage

// File: rtl/abs_signed_32.sv
// rtl/abs_signed_32.sv - combinational 32-bit two's-complement magnitude
module abs_signed_32
   import multiplication_signed_32_pkg::*;
(
   input  logic [OPERAND_WIDTH-1:0] value,
   output logic [OPERAND_WIDTH-1:0] magnitude
);

   // The most negative input maps to 32'h80000000, which reads correctly as unsigned 2^31.
   assign magnitude = value[OPERAND_WIDTH-1] ? (~value + 1'b1) : value;

endmodule

// File: rtl/multiplication_signed_32.sv
// rtl/multiplication_signed_32.sv - sequential 32x32 signed shift-add multiplier, 33-cycle latency
module multiplication_signed_32
   import multiplication_signed_32_pkg::*;
(
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic [OPERAND_WIDTH-1:0]   operand1,
   input  logic [OPERAND_WIDTH-1:0]   operand2,
   output logic [PRODUCT_WIDTH-1:0]   result,
   output logic                       finish,
   output logic                       busy
);

   mult_state_t                  state;
   mult_state_t                  next_state;
   logic [PRODUCT_WIDTH-1:0]     multiplicand;
   logic [OPERAND_WIDTH-1:0]     multiplier;
   logic [PRODUCT_WIDTH-1:0]     accumulator;
   logic [STEP_COUNT_WIDTH-1:0]  step_count;
   logic                         product_sign;
   logic [OPERAND_WIDTH-1:0]     magnitude1;
   logic [OPERAND_WIDTH-1:0]     magnitude2;
   logic                         start_accept;
   logic                         steps_done;

   abs_signed_32 abs_operand1 (
      .value     (operand1),
      .magnitude (magnitude1)
   );

   abs_signed_32 abs_operand2 (
      .value     (operand2),
      .magnitude (magnitude2)
   );

   assign start_accept = start && (state != CALC);
   assign steps_done   = (step_count == STEP_COUNT_WIDTH'(MULT_STEPS));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: if (start) next_state = CALC;
         CALC:       if (steps_done) next_state = DONE;
         default:    next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         multiplicand <= '0;
         multiplier   <= '0;
         accumulator  <= '0;
         step_count   <= '0;
         product_sign <= 1'b0;
         result       <= '0;
         finish       <= 1'b0;
         busy         <= 1'b0;
      end else if (start_accept) begin
         multiplicand <= {{(PRODUCT_WIDTH-OPERAND_WIDTH){1'b0}}, magnitude1};
         multiplier   <= magnitude2;
         product_sign <= operand1[OPERAND_WIDTH-1] ^ operand2[OPERAND_WIDTH-1];
         accumulator  <= '0;
         step_count   <= '0;
         finish       <= 1'b0;
         busy         <= 1'b1;
      end else if (state == CALC) begin
         if (steps_done) begin
            // Negating a zero accumulator yields zero, so no negative-zero special case is needed.
            result <= product_sign ? (~accumulator + 1'b1) : accumulator;
            finish <= 1'b1;
            busy   <= 1'b0;
         end else begin
            if (multiplier[0]) begin
               accumulator <= accumulator + multiplicand;
            end
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
            step_count   <= step_count + 1'b1;
         end
      end
   end

endmodule
